// File: rtl/dmem_stage_sized.sv
// MEM stage: byte/half/word data memory with registered, extended load data, optional wait
// states with a stall handshake, and registered misalign / out-of-range error pulses.
module dmem_stage_sized #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned INIT_PATTERN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch,
  input  logic              zero,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              pc_src,
  output logic [ADDR_W-1:0] alu_res_out,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              misalign,
  output logic              oob
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [IdxW-1:0]  word_idx;
  logic [1:0]       lane;
  logic             req, is_half, is_word;
  logic             mis_c, oob_c, valid_req;
  logic             do_access, do_load, do_store;
  logic [3:0]       byte_en;
  logic [31:0]      wr_lanes;
  logic [31:0]      rd_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;
  logic [31:0]      mem_words [DEPTH];

  logic [31:0]      rdata_q;
  logic             rdata_valid_q, misalign_q, oob_q;

  assign pc_src      = branch & zero;
  assign alu_res_out = addr;

  // Request decode and error classification
  assign word_idx  = addr[IdxW+1:2];
  assign lane      = addr[1:0];
  assign req       = mem_read | mem_write;
  assign is_half   = (size == 2'b01);
  assign is_word   = size[1];
  assign mis_c     = (is_half & addr[0]) | (is_word & (|addr[1:0]));
  assign oob_c     = |addr[ADDR_W-1:IdxW+2];
  assign valid_req = req & ~mis_c & ~oob_c;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (valid_req && (WAIT_STATES != 0)) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; reset forces both low so a pending access is dropped
  always_comb begin
    stall     = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall     = valid_req && (WAIT_STATES != 0);
        do_access = valid_req && (WAIT_STATES == 0);
      end
      StWait: begin
        stall     = (cnt_q != 4'd0);
        do_access = (cnt_q == 4'd0) && valid_req;
      end
      default: ;
    endcase
    if (reset) begin
      stall     = 1'b0;
      do_access = 1'b0;
    end
  end

  // A simultaneous read and write is treated as a read only
  assign do_load  = do_access & mem_read;
  assign do_store = do_access & mem_write & ~mem_read;

  // Store lane steering: replicate the right-aligned data and enable only the addressed lanes
  always_comb begin
    byte_en  = 4'b1111;
    wr_lanes = wdata;
    case (size)
      2'b00: begin
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en  = addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    // Power-up contents only; reset intentionally leaves the array alone
    logic [31:0] word_q = (INIT_PATTERN != 0) ? 32'(i) : 32'd0;

    always_ff @(posedge clk) begin
      if (do_store && (word_idx == IdxW'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) begin
            word_q[8*b +: 8] <= wr_lanes[8*b +: 8];
          end
        end
      end
    end

    assign mem_words[i] = word_q;
  end

  // Load extraction and extension
  assign rd_word = mem_words[word_idx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = rd_word[{addr[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = rd_word;
    case (size)
      2'b00:   ld_ext = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{sign_ext & ld_half[15]}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  // Registered read data and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      oob_q         <= 1'b0;
    end else begin
      rdata_valid_q <= do_load;
      if (do_load) begin
        rdata_q <= ld_ext;
      end
      misalign_q <= req & mis_c & (state_q == StIdle);
      oob_q      <= req & ~mis_c & oob_c & (state_q == StIdle);
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign misalign    = misalign_q;
  assign oob         = oob_q;

  // The upstream pipeline must hold every input while stalled
  property p_hold_while_stalled;
    @(posedge clk) disable iff (reset)
      stall |=> $stable({branch, zero, mem_read, mem_write, size, sign_ext, addr, wdata});
  endproperty
  a_hold_while_stalled: assert property (p_hold_while_stalled);

endmodule

// File: tb/tb_dmem_stage_sized.sv
// Scoreboard bench for dmem_stage_sized: two instances (0 and 3 wait states) driven against a
// byte-addressed reference memory; a negedge monitor pops expected events as outputs appear.
module tb_dmem_stage_sized;

  localparam int unsigned Depth = 256;
  localparam int unsigned Ws3   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: no wait states
  logic        br0 = 0, zr0 = 0, rd0 = 0, wr0 = 0, sx0 = 0;
  logic [1:0]  sz0 = 0;
  logic [31:0] a0 = 0, wd0 = 0;
  logic        pcs0, rdv0, st0, mis0, oob0;
  logic [31:0] alu0, rdat0;

  // Instance 1: three wait states
  logic        br3 = 0, zr3 = 0, rd3 = 0, wr3 = 0, sx3 = 0;
  logic [1:0]  sz3 = 0;
  logic [31:0] a3 = 0, wd3 = 0;
  logic        pcs3, rdv3, st3, mis3, oob3;
  logic [31:0] alu3, rdat3;

  dmem_stage_sized #(
    .DEPTH(Depth), .ADDR_W(32), .WAIT_STATES(0), .INIT_PATTERN(1)
  ) u_dut0 (
    .clk(clk), .reset(reset), .branch(br0), .zero(zr0), .mem_read(rd0), .mem_write(wr0),
    .size(sz0), .sign_ext(sx0), .addr(a0), .wdata(wd0), .pc_src(pcs0), .alu_res_out(alu0),
    .rdata(rdat0), .rdata_valid(rdv0), .stall(st0), .misalign(mis0), .oob(oob0)
  );

  dmem_stage_sized #(
    .DEPTH(Depth), .ADDR_W(32), .WAIT_STATES(Ws3), .INIT_PATTERN(1)
  ) u_dut3 (
    .clk(clk), .reset(reset), .branch(br3), .zero(zr3), .mem_read(rd3), .mem_write(wr3),
    .size(sz3), .sign_ext(sx3), .addr(a3), .wdata(wd3), .pc_src(pcs3), .alu_res_out(alu3),
    .rdata(rdat3), .rdata_valid(rdv3), .stall(st3), .misalign(mis3), .oob(oob3)
  );

  // kind: 0 load data, 1 misalign pulse, 2 oob pulse
  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t        q0[$];
  ev_t        q3[$];
  logic [7:0] mb [2][Depth*4];
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: a plain little-endian byte array
  function automatic logic [31:0] model_load(input int d, input logic [31:0] a,
                                             input int n, input logic sx);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[d][a + k]) << (8 * k));
    if (sx && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input int d, input logic [31:0] a, input int n,
                             input logic [31:0] wd);
    for (int k = 0; k < n; k++) mb[d][a + k] = wd[8*k +: 8];
  endtask

  task automatic drive(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic br, input logic zr);
    if (d == 0) begin
      rd0 = rd; wr0 = wr; sz0 = sz; sx0 = sx; a0 = a; wd0 = wd; br0 = br; zr0 = zr;
    end else begin
      rd3 = rd; wr3 = wr; sz3 = sz; sx3 = sx; a3 = a; wd3 = wd; br3 = br; zr3 = zr;
    end
  endtask

  task automatic push_ev(input int d, input ev_t e);
    if (d == 0) q0.push_back(e);
    else q3.push_back(e);
  endtask

  // One transaction: present, hold while stalled, record the expected response
  task automatic issue(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic br, input logic zr);
    int   n, stalls, exp_st;
    logic mis, oobf, vreq;
    ev_t  e;
    n      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis    = (a % n) != 0;
    oobf   = a >= Depth * 4;
    vreq   = (rd || wr) && !mis && !oobf;
    exp_st = (vreq && d != 0) ? Ws3 : 0;
    @(posedge clk); #1;
    drive(d, rd, wr, sz, sx, a, wd, br, zr);
    @(negedge clk);
    chk1($sformatf("dut%0d pc_src", d), (d == 0) ? pcs0 : pcs3, br & zr);
    chk($sformatf("dut%0d alu_res_out", d), (d == 0) ? alu0 : alu3, a);
    stalls = 0;
    while ((d == 0) ? st0 : st3) begin
      stalls++;
      if (stalls > 20) break;
      @(negedge clk);
    end
    chk($sformatf("dut%0d stall cycles @%h", d, a), 32'(stalls), 32'(exp_st));
    e.cyc  = cyc + 1;
    e.data = 32'd0;
    if (rd || wr) begin
      if (mis) begin
        e.kind = 1; push_ev(d, e);
      end else if (oobf) begin
        e.kind = 2; push_ev(d, e);
      end else if (rd) begin
        e.kind = 0; e.data = model_load(d, a, n, sx); push_ev(d, e);
      end else begin
        model_store(d, a, n, wd);
      end
    end
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Monitor: every presented output event must match the head of its scoreboard queue
  task automatic mon(input int d, input logic v, input logic m, input logic o,
                     input logic [31:0] rd);
    ev_t  e;
    logic hit;
    for (int k = 0; k < 3; k++) begin
      hit = (k == 0) ? v : (k == 1) ? m : o;
      if (hit) begin
        if ((d == 0 ? q0.size() : q3.size()) == 0) begin
          total++;
          $display("FAIL dut%0d unexpected event: got kind %0d at cycle %0d, expected none",
                   d, k, cyc);
        end else begin
          e = (d == 0) ? q0.pop_front() : q3.pop_front();
          chk($sformatf("dut%0d event kind", d), 32'(k), 32'(e.kind));
          chk($sformatf("dut%0d event cycle", d), 32'(cyc), 32'(e.cyc));
          if (k == 0) chk($sformatf("dut%0d rdata", d), rd, e.data);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, rdv0, mis0, oob0, rdat0);
      mon(1, rdv3, mis3, oob3, rdat3);
    end
  end

  task automatic directed(input int d);
    issue(d, 1, 0, 2'b10, 0, 32'h14, 32'h0, 0, 0);
    issue(d, 0, 1, 2'b10, 0, 32'h8, 32'h80FF_7F01, 0, 0);
    issue(d, 1, 0, 2'b00, 1, 32'h8, 32'h0, 0, 0);
    issue(d, 1, 0, 2'b00, 1, 32'h9, 32'h0, 0, 0);
    issue(d, 1, 0, 2'b00, 1, 32'hB, 32'h0, 0, 0);
    issue(d, 1, 0, 2'b00, 0, 32'hA, 32'h0, 0, 0);
    issue(d, 0, 1, 2'b01, 0, 32'h6, 32'h1234_BEEF, 0, 0);
    issue(d, 1, 0, 2'b10, 0, 32'h4, 32'h0, 0, 0);
    issue(d, 1, 0, 2'b01, 1, 32'h6, 32'h0, 0, 0);
    issue(d, 1, 0, 2'b01, 0, 32'h6, 32'h0, 0, 0);
    issue(d, 1, 0, 2'b10, 0, 32'h2, 32'h0, 0, 0);
    issue(d, 1, 0, 2'b10, 0, Depth * 4, 32'h0, 0, 0);
    issue(d, 0, 1, 2'b01, 0, 32'h3, 32'hFFFF_FFFF, 0, 0);
    issue(d, 1, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0);
    issue(d, 1, 1, 2'b10, 0, 32'h0, 32'h0000_DEAD, 0, 0);
    issue(d, 1, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0);
    issue(d, 0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 1);
  endtask

  task automatic random_ops(input int d, input int count);
    logic [31:0] a;
    logic [1:0]  sz;
    int          n;
    for (int i = 0; i < count; i++) begin
      sz = 2'($urandom_range(0, 3));
      n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      a  = 32'($urandom_range(0, Depth * 4 - 1));
      if ($urandom_range(0, 1) == 1) a = a & ~32'(n - 1);
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(10, 31));
      issue(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
            1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < Depth; i++)
        for (int k = 0; k < 4; k++) mb[d][4*i + k] = 8'(i >> (8 * k));

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("dut0 reset rdata", rdat0, 32'h0);
    chk("dut1 reset rdata", rdat3, 32'h0);
    chk1("dut0 reset rdata_valid", rdv0, 1'b0);
    chk1("dut1 reset rdata_valid", rdv3, 1'b0);
    chk1("dut0 reset stall", st0, 1'b0);
    chk1("dut1 reset stall", st3, 1'b0);
    chk1("dut1 reset misalign", mis3, 1'b0);
    chk1("dut1 reset oob", oob3, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    directed(0);
    directed(1);

    // Reset in the second cycle of a waited store: the store must be dropped
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 1'b0, 1'b0);
    @(negedge clk);
    chk1("dut1 stall at store start", st3, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk1("dut1 stall under reset", st3, 1'b0);
    chk1("dut1 pc_src under reset", pcs3, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("dut1 rdata after reset", rdat3, 32'h0);
    chk1("dut1 rdata_valid after reset", rdv3, 1'b0);
    issue(1, 1, 0, 2'b10, 0, 32'h20, 32'h0, 0, 0);

    random_ops(0, 250);
    random_ops(1, 250);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dut0 outstanding events", 32'(q0.size()), 32'd0);
    chk("dut1 outstanding events", 32'(q3.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
